// File: rtl/sipo_frame_receiver_if.sv
// Handshake and serial-stream bundle for the SIPO frame receiver.
// The slave modport is the receiver side. The master modport is the upstream/consumer side.
interface sipo_frame_receiver_if #(
    parameter int WIDTH = 4
);
    logic             bit_en;
    logic             sin;
    logic             sof;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             frame_err;
    logic             overrun;
    logic             clr_err;

    modport slave (
        input  bit_en, sin, sof, dout_ready, clr_err,
        output dout, dout_valid, busy, frame_err, overrun
    );

    modport master (
        output bit_en, sin, sof, dout_ready, clr_err,
        input  dout, dout_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/sipo_frame_receiver.sv
// Serial-to-parallel frame receiver. It shifts in bits MSB first, and each frame opens with an sof strobe.
// Finished words go out through a one-entry valid/ready slot, which also reports overrun and framing errors.
module sipo_frame_receiver #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    sipo_frame_receiver_if.slave    bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] word;
    logic             done, ferr_nxt, slot_free;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q, busy_q, ferr_q, ovr_q;

    // The completed word includes the bit being sampled on this edge.
    assign word      = {shreg[WIDTH-2:0], bus.sin};
    assign slot_free = !valid_q || bus.dout_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        done      = 1'b0;
        ferr_nxt  = 1'b0;
        if (bus.bit_en) begin
            case (state)
                IDLE: begin
                    if (bus.sof) begin
                        shreg_nxt = word;
                        cnt_nxt   = CW'(1);
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_nxt = word;
                    if (bus.sof) begin
                        // An sof in mid-frame drops the partial word and starts a new frame with this bit.
                        cnt_nxt  = CW'(1);
                        ferr_nxt = 1'b1;
                    end else if (cnt == CW'(WIDTH - 1)) begin
                        done      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            shreg  <= shreg_nxt;
            busy_q <= (state_nxt == SHIFT);
            ferr_q <= ferr_nxt;
            if (done && slot_free) begin
                dout_q  <= word;
                valid_q <= 1'b1;
            end else if (valid_q && bus.dout_ready) begin
                valid_q <= 1'b0;
            end
            // If an overrun and clr_err happen on the same edge, the overrun wins.
            if (done && !slot_free)
                ovr_q <= 1'b1;
            else if (bus.clr_err)
                ovr_q <= 1'b0;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_err  = ferr_q;
    assign bus.overrun    = ovr_q;
endmodule

// File: doc/sipo_frame_receiver.md
Name: sipo_frame_receiver

Overview:
Serial-to-parallel receiver that sits directly downstream of the team's parallel-in/serial-out shift register. It reassembles a WIDTH-bit word from a qualified serial bit stream, MSB first. Each frame is delimited by a start-of-frame strobe. Completed words are presented on a one-entry output register with a valid/ready handshake, and overrun and framing errors are flagged.

Parameters:
WIDTH, 4, bits per frame and width of the parallel output; legal range WIDTH >= 2.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
bit_en  input  1  qualifies sin; a bit is consumed only in cycles where bit_en=1
sin  input  1  serial data bit, MSB of the word first
sof  input  1  start of frame; valid only with bit_en=1; marks sin as bit WIDTH-1 (the MSB)
dout  output  WIDTH  received word
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready
busy  output  1  a frame is partially received (state SHIFT)
frame_err  output  1  one-cycle pulse: sof arrived mid-frame
overrun  output  1  sticky: a completed word was dropped because the output slot was full
clr_err  input  1  clears overrun

Behaviour:
- Reset (rst=1 at a clk edge) gives: state IDLE, bit count 0, shift register 0, dout 0, dout_valid 0, busy 0, frame_err 0, overrun 0. rst overrides every other input. Reset mid-frame discards the partial word and any held output word.
- Bit capture: on each consumed bit, shift <= {shift[WIDTH-2:0], sin}, and the bit count increments.
- The bit count is clog2(WIDTH)+1 bits wide. It never wraps; it is cleared on frame completion.
- IDLE:
  - bit_en=1 with sof=0: the bit is ignored. State stays IDLE, no error.
  - bit_en=1 with sof=1: capture the bit, count=1, go to SHIFT.
- SHIFT:
  - bit_en=0: hold all state.
  - bit_en=1 with sof=0: capture the bit. If this is bit WIDTH (count was WIDTH-1), the word completes: go to IDLE, count=0.
  - bit_en=1 with sof=1: the partial word is discarded. frame_err pulses high for exactly the next cycle. The bit becomes the MSB of a new frame: count=1, state stays SHIFT.
- Word completion: let slot_free = !dout_valid || dout_ready.
  - slot_free=1: dout <= completed word (including the final bit) and dout_valid <= 1, on the same edge that samples the last bit. Latency is the last-bit edge to dout_valid high one cycle later, with no gap for back-to-back frames.
  - slot_free=0: the word is dropped, dout and dout_valid are unchanged, and overrun <= 1.
- Handshake:
  - dout is stable while dout_valid=1 and dout_ready=0.
  - Handshake with no completion in the same cycle: dout_valid <= 0 and dout holds its last value.
  - Handshake and completion in the same cycle: the new word loads and dout_valid stays 1.
  - dout_ready while dout_valid=0 has no effect.
- overrun is sticky until clr_err=1 or rst. If clr_err and a new overrun occur in the same cycle, the set wins (overrun stays 1).
- busy = (state == SHIFT), driven from a register, not from inputs.
- No combinational path from any input to any output.

Test Plan:
- Reset, then WIDTH=4, dout_ready=1. Drive bits 1,0,1,1 on consecutive cycles with sof on the first. Required: dout=4'hB and dout_valid=1 in the cycle after the 4th bit; busy=1 for 3 cycles; busy=0 after.
- Gapped input: bits 0,1,1,0 with bit_en idle for 2 cycles between bits. Required: dout=4'h6; busy held through the gaps; no error.
- Backpressure, dout_ready=0: send 4'hA then 4'h5. Required: dout stays 4'hA with dout_valid=1, overrun=1, 4'h5 dropped. Then clr_err=1 for one cycle: overrun=0.
- Back-to-back with ready toggling: send 4'h3 and then 4'hC immediately, with dout_ready=1 on the cycle 4'hC completes. Required: 4'h3 accepted, 4'hC loads on the same edge, dout_valid never drops, overrun=0.
- Framing: sof, then 2 bits, then sof plus bits 1,1,1,1. Required: frame_err pulses once; dout=4'hF; no word from the aborted frame.
- Idle noise and reset mid-frame: bit_en without sof in IDLE is ignored (busy=0). Then sof plus 2 bits, then rst=1 for one cycle. Required: all outputs return to 0; a following frame 4'h9 is received correctly.
